// File: rtl/mult_share_ctrl_pkg.sv
// Shared defaults, state encoding and Booth digit encoding for the
// two-requester shared Booth multiplier controller.
package mult_share_ctrl_pkg;

  localparam int MBITS_DEF    = 12;
  localparam int NBITS_DEF    = 8;
  localparam int TREE_LAT_DEF = 2;

  localparam int PPW = MBITS_DEF + 1;
  localparam int PW  = MBITS_DEF + NBITS_DEF;
  localparam int NPP = NBITS_DEF / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_POS1 = 3'd1,
    D_POS2 = 3'd2,
    D_NEG1 = 3'd3,
    D_NEG2 = 3'd4
  } booth_digit_t;

  // Radix-4 Booth recoding of {n[2k+1], n[2k], n[2k-1]}.
  function automatic booth_digit_t booth_encode(input logic [2:0] triple);
    booth_digit_t d;
    case (triple)
      3'b001, 3'b010: d = D_POS1;
      3'b011:         d = D_POS2;
      3'b100:         d = D_NEG2;
      3'b101, 3'b110: d = D_NEG1;
      default:        d = D_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: four unshifted,
// sign-extended partial products d_k*m.
module booth_pp_gen
  import mult_share_ctrl_pkg::*;
#(
  parameter int MBITS = MBITS_DEF,
  parameter int NBITS = NBITS_DEF
) (
  input  logic [MBITS-1:0] m,
  input  logic [NBITS-1:0] n,
  output logic [MBITS:0]   pp0,
  output logic [MBITS:0]   pp1,
  output logic [MBITS:0]   pp2,
  output logic [MBITS:0]   pp3
);

  logic [MBITS:0] m_x1;
  logic [MBITS:0] m_x2;
  logic [NBITS:0] n_ext;
  logic [MBITS:0] pp [4];

  assign m_x1  = {m[MBITS-1], m};
  assign m_x2  = {m, 1'b0};
  // n_ext[0] is the implicit n[-1] = 0 of the first Booth triple.
  assign n_ext = {n, 1'b0};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pp[k] = '0;
      case (booth_encode(n_ext[2*k +: 3]))
        D_POS1:  pp[k] = m_x1;
        D_POS2:  pp[k] = m_x2;
        D_NEG1:  pp[k] = -m_x1;
        D_NEG2:  pp[k] = -m_x2;
        default: pp[k] = '0;
      endcase
    end
  end

  assign pp0 = pp[0];
  assign pp1 = pp[1];
  assign pp2 = pp[2];
  assign pp3 = pp[3];

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one Booth pp generator and an external wallace_tree between two
// requesters, round-robin arbitrated, returning id-tagged products.
module mult_share_ctrl
  import mult_share_ctrl_pkg::*;
#(
  parameter int MBITS    = MBITS_DEF,
  parameter int NBITS    = NBITS_DEF,
  parameter int TREE_LAT = TREE_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_a,
  output logic                   req_ready_a,
  input  logic [MBITS-1:0]       m_a,
  input  logic [NBITS-1:0]       n_a,
  input  logic                   req_valid_b,
  output logic                   req_ready_b,
  input  logic [MBITS-1:0]       m_b,
  input  logic [NBITS-1:0]       n_b,
  output logic [MBITS:0]         pp0,
  output logic [MBITS:0]         pp1,
  output logic [MBITS:0]         pp2,
  output logic [MBITS:0]         pp3,
  input  logic [MBITS+NBITS-1:0] tree_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [MBITS+NBITS-1:0] product
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TREE_LAT - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Requesters hold valid and operands until accepted; the response holds
  // rsp_valid, rsp_id and product until rsp_ready.

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant_a;
  logic             grant_b;
  logic             req_hs;
  logic             rsp_hs;
  logic             issue;
  logic             capture;
  logic             id_q;
  logic [MBITS-1:0] m_q;
  logic [NBITS-1:0] n_q;
  logic [CW-1:0]    cnt;
  logic [MBITS:0]   pp_c0;
  logic [MBITS:0]   pp_c1;
  logic [MBITS:0]   pp_c2;
  logic [MBITS:0]   pp_c3;

  // last_grant = 1 means B was served last, so A wins a tie.
  assign grant_a     = req_valid_a && (!req_valid_b || last_grant);
  assign grant_b     = req_valid_b && (!req_valid_a || !last_grant);
  assign req_ready_a = (state == IDLE) && !rst && grant_a;
  assign req_ready_b = (state == IDLE) && !rst && grant_b;
  assign req_hs      = (req_valid_a && req_ready_a) || (req_valid_b && req_ready_b);
  assign rsp_hs      = rsp_valid && rsp_ready;

  booth_pp_gen #(
    .MBITS (MBITS),
    .NBITS (NBITS)
  ) u_booth (
    .m   (m_q),
    .n   (n_q),
    .pp0 (pp_c0),
    .pp1 (pp_c1),
    .pp2 (pp_c2),
    .pp3 (pp_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE:    if (req_hs) state_next = ISSUE;
      ISSUE: begin
        issue      = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      m_q        <= '0;
      n_q        <= '0;
      cnt        <= '0;
      pp0        <= '0;
      pp1        <= '0;
      pp2        <= '0;
      pp3        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      product    <= '0;
    end else begin
      if (req_hs) begin
        m_q        <= req_ready_b ? m_b : m_a;
        n_q        <= req_ready_b ? n_b : n_a;
        id_q       <= req_ready_b;
        last_grant <= req_ready_b;
      end
      if (issue) begin
        pp0 <= pp_c0;
        pp1 <= pp_c1;
        pp2 <= pp_c2;
        pp3 <= pp_c3;
        cnt <= CNT_LOAD;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        product   <= tree_sum;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural wallace_tree stand-in, vector table,
// directed multi-cycle sequences and randomized traffic against a product model.
`timescale 1ns/1ps
module tb_mult_share_ctrl;

  localparam int MB = 12;
  localparam int NB = 8;
  localparam int TL = 2;
  localparam int PW = MB + NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_a = 1'b0;
  logic          req_valid_b = 1'b0;
  logic          rsp_ready = 1'b1;
  logic          req_ready_a;
  logic          req_ready_b;
  logic          rsp_valid;
  logic          rsp_id;
  logic [MB-1:0] m_a = '0;
  logic [MB-1:0] m_b = '0;
  logic [NB-1:0] n_a = '0;
  logic [NB-1:0] n_b = '0;
  logic [MB:0]   pp0, pp1, pp2, pp3;
  logic [PW-1:0] tree_sum;
  logic [PW-1:0] product;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int rsp_count = 0;
  logic [PW:0] exp_q[$];
  int hs_q[$];
  int id_log[$];
  int prod_log[$];
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_id = 1'b0;
  logic [PW-1:0] prev_prod = '0;
  logic          rand_on = 1'b0;

  typedef struct {
    logic            id;
    logic [MB-1:0]   m;
    logic [NB-1:0]   n;
    int              exp;
    logic            chk_pp;
    logic [3:0][MB:0] pp_exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_share_ctrl #(.MBITS(MB), .NBITS(NB), .TREE_LAT(TL)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_a (req_valid_a),
    .req_ready_a (req_ready_a),
    .m_a         (m_a),
    .n_a         (n_a),
    .req_valid_b (req_valid_b),
    .req_ready_b (req_ready_b),
    .m_b         (m_b),
    .n_b         (n_b),
    .pp0         (pp0),
    .pp1         (pp1),
    .pp2         (pp2),
    .pp3         (pp3),
    .tree_sum    (tree_sum),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .product     (product)
  );

  // A 13-bit pp cannot hold both +4096 and -4096; the tree reads 13'h1000 as
  // +4096 (the d=-2, m=-2048 case), so random m never draws -2048.
  function automatic int pp_val(input logic [MB:0] p);
    if (p == 13'h1000) return 4096;
    return int'($signed(p));
  endfunction

  assign tree_sum = PW'(pp_val(pp0) + 4 * pp_val(pp1) + 16 * pp_val(pp2) + 64 * pp_val(pp3));

  function automatic int model(input logic [MB-1:0] m, input logic [NB-1:0] n);
    int mi;
    int ni;
    mi = int'($signed(m));
    ni = int'($signed(n));
    return mi * ni;
  endfunction

  function automatic int sx(input logic [PW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event did not happen as required (cycle %0d)", name, cyc);
  endtask

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid_a && req_ready_a) begin
        exp_q.push_back({1'b0, PW'(model(m_a, n_a))});
        hs_q.push_back(cyc + 1);
      end
      if (req_valid_b && req_ready_b) begin
        exp_q.push_back({1'b1, PW'(model(m_b, n_b))});
        hs_q.push_back(cyc + 1);
      end
      if (req_ready_a && req_ready_b) fail("double_grant");
      if (prev_valid && !prev_ready) begin
        check("rsp_hold_valid", int'(rsp_valid), 1);
        check("rsp_hold_product", sx(product), sx(prev_prod));
        check("rsp_hold_id", int'(rsp_id), int'(prev_id));
      end
      if (rsp_valid && !prev_valid) begin
        if (hs_q.size() == 0) fail("rsp_without_request");
        else check("rsp_latency", cyc - hs_q[0], TL + 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail("rsp_stale");
        end else begin
          check("rsp_id", int'(rsp_id), int'(exp_q[0][PW]));
          check("rsp_product", sx(product), sx(exp_q[0][PW-1:0]));
          exp_q.delete(0);
          if (hs_q.size() != 0) hs_q.delete(0);
        end
        rsp_count <= rsp_count + 1;
        id_log.push_back(int'(rsp_id));
        prod_log.push_back(sx(product));
      end
      prev_valid <= rsp_valid;
      prev_ready <= rsp_ready;
      prev_id    <= rsp_id;
      prev_prod  <= product;
    end else begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the request handshake.
  task automatic send(input logic id, input logic [MB-1:0] m, input logic [NB-1:0] n);
    int w;
    if (id) begin req_valid_b = 1'b1; m_b = m; n_b = n; end
    else    begin req_valid_a = 1'b1; m_a = m; n_a = n; end
    #1;
    w = 0;
    while (!(id ? req_ready_b : req_ready_a) && w < 300) begin
      @(posedge clk); #2;
      w++;
    end
    if (w >= 300) fail(id ? "send_b_timeout" : "send_a_timeout");
    @(posedge clk); #1;
    if (id) req_valid_b = 1'b0;
    else    req_valid_a = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string name);
    int w;
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(posedge clk); #2;
      w++;
    end
    if (w >= 50) fail(name);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) fail("drain_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int w;
    vecs[0] = '{1'b0, 12'd3,     8'd5,    15,     1'b1, {13'd0, 13'd0, 13'd0, 13'd0}};
    vecs[0].pp_exp = {13'd0, 13'd0, 13'd3, 13'd3};
    vecs[1] = '{1'b0, 12'h800,   8'h80,   262144, 1'b1, {13'h1000, 13'd0, 13'd0, 13'd0}};
    vecs[2] = '{1'b1, 12'd2047,  8'd127,  259969, 1'b0, {13'd0, 13'd0, 13'd0, 13'd0}};
    vecs[3] = '{1'b0, -12'sd7,   8'd9,    -63,    1'b0, {13'd0, 13'd0, 13'd0, 13'd0}};
    vecs[4] = '{1'b1, -12'sd1234, 8'd0,   0,      1'b1, {13'd0, 13'd0, 13'd0, 13'd0}};
    vecs[5] = '{1'b0, 12'd0,     8'h80,   0,      1'b1, {13'd0, 13'd0, 13'd0, 13'd0}};
    vecs[6] = '{1'b0, 12'd100,   8'hff,   -100,   1'b0, {13'd0, 13'd0, 13'd0, 13'd0}};
    vecs[7] = '{1'b1, 12'h800,   8'd0,    0,      1'b1, {13'd0, 13'd0, 13'd0, 13'd0}};

    // Reset state, with A requesting during reset.
    repeat (2) @(posedge clk);
    #1 req_valid_a = 1'b1;
    #1;
    check("reset_ready_a", int'(req_ready_a), 0);
    check("reset_ready_b", int'(req_ready_b), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_product", sx(product), 0);
    check("reset_pp", int'({pp3, pp2, pp1, pp0} != '0), 0);
    req_valid_a = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].id, vecs[i].m, vecs[i].n);
      wait_rsp_valid($sformatf("vec%0d_rsp_timeout", i));
      check($sformatf("vec%0d_product", i), sx(product), vecs[i].exp);
      check($sformatf("vec%0d_id", i), int'(rsp_id), int'(vecs[i].id));
      if (vecs[i].chk_pp) begin
        check($sformatf("vec%0d_pp0", i), int'(pp0), int'(vecs[i].pp_exp[0]));
        check($sformatf("vec%0d_pp1", i), int'(pp1), int'(vecs[i].pp_exp[1]));
        check($sformatf("vec%0d_pp2", i), int'(pp2), int'(vecs[i].pp_exp[2]));
        check($sformatf("vec%0d_pp3", i), int'(pp3), int'(vecs[i].pp_exp[3]));
      end
      drain();
    end

    // Both requesters held valid: grants alternate A, B, A, B.
    id_log.delete();
    fork
      begin send(1'b0, 12'd1, 8'd1); send(1'b0, 12'd3, 8'd3); end
      begin send(1'b1, 12'd2, 8'd2); send(1'b1, 12'd4, 8'd4); end
    join
    drain();
    check("alt_count", id_log.size(), 4);
    if (id_log.size() == 4) begin
      check("alt_id0", id_log[0], 0);
      check("alt_id1", id_log[1], 1);
      check("alt_id2", id_log[2], 0);
      check("alt_id3", id_log[3], 1);
    end

    // Response back-pressure for 5 cycles, B waiting meanwhile.
    rsp_ready = 1'b0;
    c0 = rsp_count;
    send(1'b0, -12'sd7, 8'd9);
    wait_rsp_valid("bp_rsp_timeout");
    #1 req_valid_b = 1'b1; m_b = 12'd5; n_b = 8'd6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_product", sx(product), -63);
      check("bp_ready_a", int'(req_ready_a), 0);
      check("bp_ready_b", int'(req_ready_b), 0);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_rsp_dropped", int'(rsp_valid), 0);
    check("bp_single_hs", rsp_count - c0, 1);
    w = 0;
    while (!req_ready_b && w < 20) begin @(posedge clk); #2; w++; end
    if (w >= 20) fail("bp_b_not_served");
    @(posedge clk); #1 req_valid_b = 1'b0;
    drain();
    check("bp_total_rsp", rsp_count - c0, 2);

    // Reset during SETTLE: outputs clear at once, in-flight result discarded.
    send(1'b0, 12'd11, 8'd13);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    hs_q.delete();
    #1;
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    check("midrst_rsp_id", int'(rsp_id), 0);
    check("midrst_product", sx(product), 0);
    check("midrst_pp", int'({pp3, pp2, pp1, pp0} != '0), 0);
    check("midrst_ready_a", int'(req_ready_a), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = rsp_count;
    id_log.delete();
    prod_log.delete();
    req_valid_a = 1'b1; m_a = 12'd100; n_a = 8'hff;
    req_valid_b = 1'b1; m_b = 12'd5;   n_b = 8'd5;
    #1;
    w = 0;
    while (!req_ready_a && w < 20) begin @(posedge clk); #2; w++; end
    if (w >= 20) fail("postrst_a_not_served");
    @(posedge clk); #1 req_valid_a = 1'b0;
    w = 0;
    while (!req_ready_b && w < 40) begin @(posedge clk); #2; w++; end
    if (w >= 40) fail("postrst_b_not_served");
    @(posedge clk); #1 req_valid_b = 1'b0;
    drain();
    check("postrst_rsp_count", rsp_count - c0, 2);
    if (id_log.size() == 2) begin
      check("postrst_first_id", id_log[0], 0);
      check("postrst_first_prod", prod_log[0], -100);
      check("postrst_second_prod", prod_log[1], 25);
    end

    // Randomized traffic from both requesters with random back-pressure.
    rand_on = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 20; i++) begin
            int mt;
            mt = int'($urandom_range(0, 4094)) - 2047;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(1'b0, MB'(mt), NB'($urandom));
          end
          for (int i = 0; i < 20; i++) begin
            int mt;
            mt = int'($urandom_range(0, 4094)) - 2047;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(1'b1, MB'(mt), NB'($urandom));
          end
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
